math_equation_solver: RTL and testbench

- Inverse of the pipelined equation unit q = ((1 + 3*c)*(a - b) - 4*d) >>> 1.
- Given a result q plus the operands a, c and d, it recovers operand b. It also flags inputs that no integer b can produce.
- Sits on the verification/readback side, behind the equation unit's output stream.
- Multi-cycle: an FSM drives a sequential restoring divider, with valid/ready handshakes on both sides.

---
 rtl/math_equation_solver.sv | 227 ++++++++++++++++++++++
 tb/tb_math_equation_solver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/math_equation_solver.sv
`default_nettype none
// ============================================================================
//  Module   : math_equation_solver
//  Purpose  : Recovers operand b of q = ((1 + 3*c)*(a - b) - 4*d) >>> 1
//             from q, a, c and d using a sequential restoring divider.
//             err_o flags inputs that no integer b can produce.
//  Option   : MATH_EQUATION_SOLVER_CHECK_EN adds a CHECK state that
//             re-evaluates the forward equation with the recovered b.
//  Revision : 1.0 - initial release
// ============================================================================
module math_equation_solver #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2*WIDTH+1:0]   q_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     c_i,
    input  logic [WIDTH-1:0]     d_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     b_o,
    output logic                 err_o
);

    localparam int c_QW = 2*WIDTH+2;        // q width
    localparam int c_NW = 2*WIDTH+3;        // numerator width / divide steps
    localparam int c_DW = WIDTH+3;          // denominator width
    localparam int c_XW = c_NW+2;           // signed quotient width
    localparam int c_CW = $clog2(c_NW+1);   // step counter width

    localparam logic [c_CW-1:0]        c_LAST     = c_CW'(c_NW-1);
    localparam logic [c_CW-1:0]        c_CNT_ONE  = 1;
    localparam logic [c_DW-1:0]        c_DW_ONE   = 1;
    localparam logic signed [c_DW-1:0] c_DEN_ONE  = 1;
    localparam logic [c_XW-1:0]        c_XW_ONE   = 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef MATH_EQUATION_SOLVER_CHECK_EN
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam int         c_PW    = 2*WIDTH+5;  // forward-check width
`endif

    logic [2:0]        r_state;
    logic [c_QW-1:0]   r_q;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_c;
    logic [WIDTH-1:0]  r_d;
    logic [c_DW-1:0]   r_den_mag;
    logic              r_sn;
    logic              r_sd;
    logic [c_NW-1:0]   r_quo;     // dividend shifting out, quotient shifting in
    logic [c_DW-1:0]   r_rem;
    logic [c_CW-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Operand preparation: den = 1 + 3c, num = 2q + 4d and magnitudes
    // ------------------------------------------------------------------
    logic signed [c_DW-1:0] w_c_ext;
    logic signed [c_DW-1:0] w_den;
    logic [c_DW-1:0]        w_den_mag;
    logic [c_NW-1:0]        w_num;
    logic [c_NW-1:0]        w_num_mag;

    assign w_c_ext   = $signed({{3{r_c[WIDTH-1]}}, r_c});
    assign w_den     = w_c_ext + (w_c_ext <<< 1) + c_DEN_ONE;
    assign w_den_mag = w_den[c_DW-1] ? -w_den : w_den;
    assign w_num     = {r_q, 1'b0} + {{(c_NW-WIDTH-2){r_d[WIDTH-1]}}, r_d, 2'b00};
    assign w_num_mag = w_num[c_NW-1] ? -w_num : w_num;

    // ------------------------------------------------------------------
    // Restoring divider step: shift in next dividend bit, try subtract
    // ------------------------------------------------------------------
    logic [c_DW:0] w_trial;
    logic          w_ge;

    assign w_trial = {r_rem, r_quo[c_NW-1]};
    assign w_ge    = (w_trial >= {1'b0, r_den_mag});

    // ------------------------------------------------------------------
    // Fix-up: choose between num and num+1 as the true product
    // ------------------------------------------------------------------
    logic [c_XW-1:0]    w_qm_ext;
    logic [c_XW-1:0]    w_mag;
    logic               w_neg;
    logic               w_bad;
    logic [c_XW-1:0]    w_qs;
    logic [c_XW-WIDTH:0] w_hi;
    logic               w_oob;
    logic [WIDTH-1:0]   w_b;

    assign w_qm_ext = {2'b00, r_quo};

    // Select quotient magnitude and sign from the remainder pattern
    always_comb begin
        w_mag = w_qm_ext;
        w_neg = r_sn ^ r_sd;
        w_bad = 1'b0;
        if (r_rem == '0) begin
            w_mag = w_qm_ext;
            w_neg = r_sn ^ r_sd;
        end else if (!r_sn && (r_rem == (r_den_mag - c_DW_ONE))) begin
            // num+1 divides exactly and is one more multiple of |den|
            w_mag = w_qm_ext + c_XW_ONE;
            w_neg = r_sd;
        end else if (r_sn && (r_rem == c_DW_ONE)) begin
            // num+1 = -(Qm*|den|); a zero magnitude negates to zero
            w_mag = w_qm_ext;
            w_neg = !r_sd;
        end else begin
            w_bad = 1'b1;
        end
    end

    assign w_qs  = w_neg ? -w_mag : w_mag;
    assign w_hi  = w_qs[c_XW-1:WIDTH-1];
    assign w_oob = !((&w_hi) || (~|w_hi));
    assign w_b   = r_a - w_qs[WIDTH-1:0];

`ifdef MATH_EQUATION_SOLVER_CHECK_EN
    // ------------------------------------------------------------------
    // Forward re-evaluation of the equation with the recovered b
    // ------------------------------------------------------------------
    logic signed [WIDTH:0]  w_chk_x;
    logic signed [c_PW-1:0] w_chk_prod;
    logic signed [c_PW-1:0] w_chk_p;
    logic [c_PW-1:0]        w_chk_q;
    logic                   w_chk_bad;

    assign w_chk_x    = $signed({r_a[WIDTH-1], r_a}) - $signed({b_o[WIDTH-1], b_o});
    assign w_chk_prod = $signed({{(c_PW-WIDTH-1){w_chk_x[WIDTH]}}, w_chk_x})
                      * $signed({{(c_PW-c_DW){w_den[c_DW-1]}}, w_den});
    assign w_chk_p    = w_chk_prod - $signed({{(c_PW-WIDTH-2){r_d[WIDTH-1]}}, r_d, 2'b00});
    assign w_chk_q    = w_chk_p >>> 1;
    assign w_chk_bad  = (w_chk_q != {{3{r_q[c_QW-1]}}, r_q});
`endif

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            b_o       <= '0;
            err_o     <= 1'b0;
            r_q       <= '0;
            r_a       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_den_mag <= '0;
            r_sn      <= 1'b0;
            r_sd      <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i && ready_o) begin
                        r_q     <= q_i;
                        r_a     <= a_i;
                        r_c     <= c_i;
                        r_d     <= d_i;
                        ready_o <= 1'b0;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_den_mag <= w_den_mag;
                    r_sd      <= w_den[c_DW-1];
                    r_sn      <= w_num[c_NW-1];
                    r_quo     <= w_num_mag;
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_DIV;
                end
                S_DIV: begin
                    r_quo <= {r_quo[c_NW-2:0], w_ge};
                    r_rem <= w_ge ? c_DW'(w_trial - {1'b0, r_den_mag})
                                  : w_trial[c_DW-1:0];
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    b_o   <= w_b;
                    err_o <= w_bad || w_oob;
`ifdef MATH_EQUATION_SOLVER_CHECK_EN
                    r_state <= S_CHECK;
`else
                    valid_o <= 1'b1;
                    r_state <= S_DONE;
`endif
                end
`ifdef MATH_EQUATION_SOLVER_CHECK_EN
                S_CHECK: begin
                    err_o   <= err_o || w_chk_bad;
                    valid_o <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                        ready_o <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_math_equation_solver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_math_equation_solver
//  Purpose  : Scoreboard bench for math_equation_solver with directed vectors
//  Revision : 1.0 - initial release
// ============================================================================
module tb_math_equation_solver;

`ifdef MATH_EQUATION_SOLVER_CHECK_EN
    localparam int c_LAT = 38;
`else
    localparam int c_LAT = 37;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [33:0] q_i = '0;
    logic [15:0] a_i = '0;
    logic [15:0] c_i = '0;
    logic [15:0] d_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [15:0] b_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] b;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic lat_done = 1'b0;

    math_equation_solver #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .q_i     (q_i),
        .a_i     (a_i),
        .c_i     (c_i),
        .d_i     (d_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .b_o     (b_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake
    always begin
        @(negedge clk);
        #2;
        if (valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no pending result (t=%0t)", $time);
            end else begin
                if (!lat_done) begin
                    chk("latency", 64'(cyc - sb[0].acc), 64'(c_LAT));
                    lat_done = 1'b1;
                end
                if (ready_i) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_o", {63'd0, err_o}, {63'd0, e.err});
                    if (!e.err) chk("b_o", {48'd0, b_o}, {48'd0, e.b});
                    lat_done = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic signed [33:0] q, input logic [15:0] a,
                        input logic [15:0] c, input logic [15:0] d,
                        input logic [15:0] eb, input logic ee);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("ready_timeout", {63'd0, ready_o}, 64'd1);
            return;
        end
        q_i = q; a_i = a; c_i = c; d_i = d;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        e.b = eb; e.err = ee; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic signed [33:0] q, input logic [15:0] a,
                       input logic [15:0] c, input logic [15:0] d,
                       input logic [15:0] eb, input logic ee);
        send(q, a, c, d, eb, ee);
        drain();
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hb;
        logic        he;
        int          n;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_b_o",     {48'd0, b_o},     64'd0);
        chk("rst_err_o",   {63'd0, err_o},   64'd0);
        @(negedge clk);
        rst = 1'b0;

        //   q       a        c        d        b        err
        run(22,     16'd10,  16'd2,   16'd1,   16'd3,   1'b0); // Rm = |den|-1
        run(3,      16'd5,   16'hFFFF,16'd0,   16'd8,   1'b0); // den = -2, exact
        run(-4,     16'd0,   16'd2,   16'd0,   16'd1,   1'b0); // negative num, Rm = 1
        run(-10,    16'd0,   16'd1,   16'd0,   16'd5,   1'b0);
        run(1,      16'd0,   16'd1,   16'd0,   16'd0,   1'b1); // inconsistent
        run(310,    16'd100, 16'd3,   16'hFFFB,16'd40,  1'b0); // negative d
        run(-8,     16'd7,   16'hFFFE,16'd0,   16'd4,   1'b0); // den=-5, sn, Q=+3
        run(7,      16'd7,   16'hFFFE,16'd0,   16'd10,  1'b0); // den=-5, !sn, Q=-3
        run(5,      16'd0,   16'd0,   16'd0,   16'hFFF6,1'b0); // |den|=1 tie-break
        run(-16384, 16'hFFFF,16'd0,   16'd0,   16'h7FFF,1'b0); // Q = -32768
        run(-32767, 16'h7FFF,16'hFFFF,16'd0,   16'd0,   1'b0); // Q = 32767
        run(-32768, 16'd0,   16'hFFFF,16'd0,   16'd0,   1'b1); // Q = 32768 out of range
        run(34'sd1048576, 16'd0, 16'd0, 16'd0, 16'd0,   1'b1); // far out of range

        // Back-pressure: result held while extra requests are offered
        ready_i = 1'b0;
        send(22, 16'd10, 16'd2, 16'd1, 16'd3, 1'b0);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            #2;
            if (valid_o) break;
            n++;
        end
        chk("bp_valid_seen", {63'd0, valid_o}, 64'd1);
        hb = b_o;
        he = err_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_i = (i % 2 == 0);
            #2;
            chk("bp_valid_o", {63'd0, valid_o}, 64'd1);
            chk("bp_b_o",     {48'd0, b_o},     {48'd0, hb});
            chk("bp_err_o",   {63'd0, err_o},   {63'd0, he});
            chk("bp_ready_o", {63'd0, ready_o}, 64'd0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_ready_after", {63'd0, ready_o}, 64'd1);
        chk("bp_valid_after", {63'd0, valid_o}, 64'd0);
        drain();

        // Reset in the middle of the division
        send(-10, 16'd0, 16'd1, 16'd0, 16'd5, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready_o", {63'd0, ready_o}, 64'd1);
        chk("midrst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("midrst_b_o",     {48'd0, b_o},     64'd0);
        chk("midrst_err_o",   {63'd0, err_o},   64'd0);
        sb.delete();
        lat_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);   // any stale valid_o is flagged by the monitor
        run(22, 16'd10, 16'd2, 16'd1, 16'd3, 1'b0);
        run(-4, 16'd0,  16'd2, 16'd0, 16'd1, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
